fir_seq_ctrl: RTL and testbench

FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

---
 rtl/fir_seq_ctrl.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_fir_seq_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: sequences one FIR job. It loads the taps, length and start
// over AXI-Lite, then bridges the source/sink streams to the FIR AXI-Stream
// ports while counting beats and checking tlast. Finally it polls ap_done and
// pulses done.
module fir_seq_ctrl #(
   parameter int pADDR_WIDTH = 12,
   parameter int pDATA_WIDTH = 32,
   parameter int Tape_Num    = 11
) (
   input  logic                   axis_clk,
   input  logic                   axis_rst_n,
   // job control
   input  logic                   start,
   input  logic [31:0]            cfg_len,
   input  logic [3:0]             cfg_ntap,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   // coefficient source
   output logic [3:0]             coef_idx,
   input  logic [31:0]            coef_data,
   // sample source
   input  logic                   src_valid,
   input  logic [31:0]            src_data,
   output logic                   src_ready,
   // result sink
   output logic                   dst_valid,
   output logic [31:0]            dst_data,
   input  logic                   dst_ready,
   // AXI-Lite master
   output logic                   awvalid,
   output logic [pADDR_WIDTH-1:0] awaddr,
   input  logic                   awready,
   output logic                   wvalid,
   output logic [pDATA_WIDTH-1:0] wdata,
   input  logic                   wready,
   output logic                   arvalid,
   output logic [pADDR_WIDTH-1:0] araddr,
   input  logic                   arready,
   input  logic                   rvalid,
   input  logic [pDATA_WIDTH-1:0] rdata,
   output logic                   rready,
   // AXI-Stream to FIR
   output logic                   ss_tvalid,
   output logic [pDATA_WIDTH-1:0] ss_tdata,
   output logic                   ss_tlast,
   input  logic                   ss_tready,
   // AXI-Stream from FIR
   input  logic                   sm_tvalid,
   input  logic [pDATA_WIDTH-1:0] sm_tdata,
   input  logic                   sm_tlast,
   output logic                   sm_tready
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WR_TAP   = 3'd1,
      WR_LEN   = 3'd2,
      WR_START = 3'd3,
      STREAM   = 3'd4,
      POLL     = 3'd5,
      FIN      = 3'd6
   } state_t;

   localparam logic [3:0]             NTAP_MAX  = 4'(Tape_Num);
   localparam logic [pADDR_WIDTH-1:0] CTRL_ADDR = pADDR_WIDTH'(32'h00);
   localparam logic [pADDR_WIDTH-1:0] LEN_ADDR  = pADDR_WIDTH'(32'h10);
   localparam logic [pADDR_WIDTH-1:0] TAP_BASE  = pADDR_WIDTH'(32'h40);

   state_t                   state_q;
   logic [31:0]              len_q;
   logic [3:0]               ntap_q;
   logic [3:0]               coef_idx_q;
   logic [31:0]              in_cnt_q;
   logic [31:0]              out_cnt_q;
   logic                     busy_q;
   logic                     done_q;
   logic                     err_q;
   logic                     awvalid_q;
   logic [pADDR_WIDTH-1:0]   awaddr_q;
   logic                     wvalid_q;
   logic [pDATA_WIDTH-1:0]   wdata_q;
   logic                     wr_act_q;
   logic                     arvalid_q;
   logic                     rready_q;
   logic                     rd_act_q;

   logic                     stream_s;
   logic                     in_open_s;
   logic [31:0]              len_m1_s;
   logic                     ss_hs_s;
   logic                     sm_hs_s;
   logic                     wr_fin_s;
   logic                     last_out_s;
   logic [3:0]               ntap_cfg_s;
   logic [pADDR_WIDTH-1:0]   wr_addr_s;
   logic [pDATA_WIDTH-1:0]   wr_data_s;
   logic                     rdata_unused_s;

   // Only ap_done is inspected; the remaining status bits are don't-care.
   assign rdata_unused_s = ^rdata;

   assign stream_s   = (state_q == STREAM);
   assign in_open_s  = stream_s && (in_cnt_q < len_q);
   assign len_m1_s   = len_q - 32'd1;
   assign last_out_s = (out_cnt_q == len_m1_s);

   // Stream bridges are combinational so a beat passes in the cycle it is offered.
   assign ss_tvalid = in_open_s & src_valid;
   assign ss_tdata  = in_open_s ? src_data : '0;
   assign ss_tlast  = in_open_s && (in_cnt_q == len_m1_s);
   assign src_ready = in_open_s & ss_tready;
   assign dst_valid = stream_s & sm_tvalid;
   assign dst_data  = stream_s ? sm_tdata : '0;
   assign sm_tready = stream_s & dst_ready;

   assign ss_hs_s = ss_tvalid & ss_tready;
   assign sm_hs_s = sm_tvalid & sm_tready;

   // A write is finished once each channel has either already been accepted
   // or is being accepted on this edge, regardless of which came first.
   assign wr_fin_s = wr_act_q && (!awvalid_q || awready) && (!wvalid_q || wready);

   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;
   assign coef_idx = coef_idx_q;
   assign awvalid  = awvalid_q;
   assign awaddr   = awaddr_q;
   assign wvalid   = wvalid_q;
   assign wdata    = wdata_q;
   assign arvalid  = arvalid_q;
   assign araddr   = CTRL_ADDR;
   assign rready   = rready_q;

   // Clamp an out-of-range tap count to the full filter length.
   always_comb begin
      ntap_cfg_s = NTAP_MAX;
      if ((cfg_ntap == 4'd0) || (cfg_ntap > NTAP_MAX)) begin
         ntap_cfg_s = NTAP_MAX;
      end else begin
         ntap_cfg_s = cfg_ntap;
      end
   end

   // Select address/data for the write owned by the current state.
   always_comb begin
      wr_addr_s = '0;
      wr_data_s = '0;
      case (state_q)
         WR_TAP: begin
            wr_addr_s = TAP_BASE + pADDR_WIDTH'({coef_idx_q, 2'b00});
            wr_data_s = pDATA_WIDTH'(coef_data);
         end
         WR_LEN: begin
            wr_addr_s = LEN_ADDR;
            wr_data_s = pDATA_WIDTH'(len_q);
         end
         WR_START: begin
            wr_addr_s = CTRL_ADDR;
            wr_data_s = pDATA_WIDTH'(32'd1);
         end
         default: begin
            wr_addr_s = '0;
            wr_data_s = '0;
         end
      endcase
   end

   // Job sequencer: state, counters and all registered outputs.
   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         state_q    <= IDLE;
         len_q      <= 32'd0;
         ntap_q     <= 4'd0;
         coef_idx_q <= 4'd0;
         in_cnt_q   <= 32'd0;
         out_cnt_q  <= 32'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         awvalid_q  <= 1'b0;
         awaddr_q   <= '0;
         wvalid_q   <= 1'b0;
         wdata_q    <= '0;
         wr_act_q   <= 1'b0;
         arvalid_q  <= 1'b0;
         rready_q   <= 1'b0;
         rd_act_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  len_q      <= cfg_len;
                  ntap_q     <= ntap_cfg_s;
                  coef_idx_q <= 4'd0;
                  busy_q     <= 1'b1;
                  err_q      <= 1'b0;
                  state_q    <= (cfg_len == 32'd0) ? FIN : WR_TAP;
               end
            end
            WR_TAP, WR_LEN, WR_START: begin
               if (!wr_act_q) begin
                  awvalid_q <= 1'b1;
                  wvalid_q  <= 1'b1;
                  awaddr_q  <= wr_addr_s;
                  wdata_q   <= wr_data_s;
                  wr_act_q  <= 1'b1;
               end else begin
                  if (awready) begin
                     awvalid_q <= 1'b0;
                  end
                  if (wready) begin
                     wvalid_q <= 1'b0;
                  end
                  if (wr_fin_s) begin
                     wr_act_q <= 1'b0;
                     awaddr_q <= '0;
                     wdata_q  <= '0;
                     case (state_q)
                        WR_TAP: begin
                           if (coef_idx_q == (ntap_q - 4'd1)) begin
                              coef_idx_q <= 4'd0;
                              state_q    <= WR_LEN;
                           end else begin
                              coef_idx_q <= coef_idx_q + 4'd1;
                           end
                        end
                        WR_LEN: begin
                           state_q <= WR_START;
                        end
                        default: begin
                           in_cnt_q  <= 32'd0;
                           out_cnt_q <= 32'd0;
                           state_q   <= STREAM;
                        end
                     endcase
                  end
               end
            end
            STREAM: begin
               if (ss_hs_s) begin
                  in_cnt_q <= in_cnt_q + 32'd1;
               end
               if (sm_hs_s) begin
                  out_cnt_q <= out_cnt_q + 32'd1;
                  if (sm_tlast != last_out_s) begin
                     err_q <= 1'b1;
                  end
                  if (last_out_s) begin
                     state_q <= POLL;
                  end
               end
            end
            POLL: begin
               if (!rd_act_q) begin
                  arvalid_q <= 1'b1;
                  rd_act_q  <= 1'b1;
               end else begin
                  if (arvalid_q && arready) begin
                     arvalid_q <= 1'b0;
                     rready_q  <= 1'b1;
                  end
                  if (rready_q && rvalid) begin
                     rready_q <= 1'b0;
                     rd_act_q <= 1'b0;
                     if (rdata[1]) begin
                        state_q <= FIN;
                     end
                  end
               end
            end
            FIN: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl: AXI-Lite slave, FIR stream model and
// source/sink models run in one background process; the initial block runs jobs.
module tb_fir_seq_ctrl;

   localparam int AW = 12;
   localparam int DW = 32;

   logic          axis_clk   = 1'b0;
   logic          axis_rst_n = 1'b0;
   logic          start      = 1'b0;
   logic [31:0]   cfg_len    = 32'd0;
   logic [3:0]    cfg_ntap   = 4'd0;
   logic          busy, done, err;
   logic [3:0]    coef_idx;
   logic [31:0]   coef_data;
   logic          src_valid  = 1'b0;
   logic [31:0]   src_data   = 32'd0;
   logic          src_ready;
   logic          dst_valid;
   logic [31:0]   dst_data;
   logic          dst_ready  = 1'b0;
   logic          awvalid, wvalid, arvalid, rready;
   logic [AW-1:0] awaddr, araddr;
   logic [DW-1:0] wdata;
   logic          awready    = 1'b0;
   logic          wready     = 1'b0;
   logic          arready    = 1'b0;
   logic          rvalid     = 1'b0;
   logic [DW-1:0] rdata      = '0;
   logic          ss_tvalid, ss_tlast;
   logic [DW-1:0] ss_tdata;
   logic          ss_tready  = 1'b0;
   logic          sm_tvalid  = 1'b0;
   logic [DW-1:0] sm_tdata   = '0;
   logic          sm_tlast   = 1'b0;
   logic          sm_tready;

   fir_seq_ctrl #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(11)) dut (
      .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
      .start(start), .cfg_len(cfg_len), .cfg_ntap(cfg_ntap),
      .busy(busy), .done(done), .err(err),
      .coef_idx(coef_idx), .coef_data(coef_data),
      .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
      .dst_valid(dst_valid), .dst_data(dst_data), .dst_ready(dst_ready),
      .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
      .wvalid(wvalid), .wdata(wdata), .wready(wready),
      .arvalid(arvalid), .araddr(araddr), .arready(arready),
      .rvalid(rvalid), .rdata(rdata), .rready(rready),
      .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
      .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready)
   );

   always #5 axis_clk = ~axis_clk;

   // Coefficient ROM: tap i reads as C0DE_0000 + i in the same cycle.
   assign coef_data = 32'hC0DE_0000 + 32'(coef_idx);

   int n_asrt = 0;
   int n_fail = 0;

   // model knobs and logs
   int unsigned   cyc = 0;
   bit            stall_en = 1'b0;
   int            aw_dly = 0, w_dly = 0, poll_need = 1, tlast_at = 0, src_n = 0;
   logic [AW-1:0] aw_log[$];
   logic [DW-1:0] w_log[$];
   logic [31:0]   fir_q[$];
   logic [31:0]   dst_log[$];
   int            n_ar, n_r, ar_bad, stab_bad, pass_bad;
   int            ss_beats, ss_last_cnt, ss_last_pos, done_cnt;
   int            src_idx, sm_idx, aw_wait, w_wait;
   bit            aw_held, w_held;
   logic [AW-1:0] aw_hold;
   logic [DW-1:0] w_hold;
   logic [31:0]   ss_data_f;
   bit            src_fire_f, ss_fire_f, sm_fire_f, ar_fire_f, r_fire_f;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge axis_clk);
      #2;
   endtask

   task automatic clear_model();
      aw_log.delete(); w_log.delete(); fir_q.delete(); dst_log.delete();
      n_ar = 0; n_r = 0; ar_bad = 0; stab_bad = 0; pass_bad = 0;
      ss_beats = 0; ss_last_cnt = 0; ss_last_pos = -1; done_cnt = 0;
      src_idx = 0; sm_idx = 0; aw_wait = 0; w_wait = 0;
      aw_held = 1'b0; w_held = 1'b0;
      src_fire_f = 1'b0; ss_fire_f = 1'b0; sm_fire_f = 1'b0; ar_fire_f = 1'b0; r_fire_f = 1'b0;
      rvalid = 1'b0; rdata = '0;
   endtask

   task automatic start_job(input logic [31:0] len, input logic [3:0] ntap, input int tl);
      clear_model();
      src_n    = int'(len);
      tlast_at = tl;
      start    = 1'b1;
      cfg_len  = len;
      cfg_ntap = ntap;
      tick();
      start    = 1'b0;
      cfg_len  = 32'd0;
      cfg_ntap = 4'd0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      for (int i = 0; i < budget && done_cnt == 0; i++) tick();
      check({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
      repeat (4) tick();
   endtask

   function automatic logic any_out();
      return |{busy, done, err, coef_idx, src_ready, dst_valid, dst_data, awvalid, awaddr,
               wvalid, wdata, arvalid, araddr, rready, ss_tvalid, ss_tdata, ss_tlast, sm_tready};
   endfunction

   // Background models: apply last edge's handshakes, drive inputs, then sample
   // the handshakes the coming rising edge will take.
   always begin
      @(negedge axis_clk);
      cyc++;
      if (src_fire_f) src_idx++;
      if (ss_fire_f) fir_q.push_back(ss_data_f);
      if (sm_fire_f) begin
         void'(fir_q.pop_front());
         sm_idx++;
      end
      if (r_fire_f) begin
         rvalid = 1'b0;
         rdata  = '0;
         n_r++;
      end
      if (ar_fire_f) begin
         rvalid = 1'b1;
         rdata  = (n_r + 1 >= poll_need) ? 32'h6 : 32'h0;
      end
      src_valid = (src_idx < src_n) && (!stall_en || (cyc % 3) != 1);
      src_data  = 32'h1000 + 32'(src_idx);
      ss_tready = !stall_en || (cyc % 4) != 2;
      sm_tvalid = (fir_q.size() > 0) && (!stall_en || (cyc % 5) != 3);
      sm_tdata  = (fir_q.size() > 0) ? fir_q[0] + 32'h100 : 32'h0;
      sm_tlast  = sm_tvalid && (sm_idx == tlast_at);
      dst_ready = !stall_en || (cyc % 3) != 0;
      awready   = awvalid && (aw_wait >= aw_dly);
      wready    = wvalid && (w_wait >= w_dly);
      arready   = arvalid;
      #1;
      src_fire_f = src_valid && src_ready;
      ss_fire_f  = ss_tvalid && ss_tready;
      ss_data_f  = ss_tdata;
      if (ss_fire_f) begin
         if (ss_tdata !== src_data) pass_bad++;
         if (ss_tlast) begin
            ss_last_cnt++;
            ss_last_pos = ss_beats;
         end
         ss_beats++;
      end
      sm_fire_f = sm_tvalid && sm_tready;
      if (dst_valid && dst_ready) dst_log.push_back(dst_data);
      ar_fire_f = arvalid && arready;
      if (ar_fire_f) begin
         n_ar++;
         if (araddr !== '0) ar_bad++;
      end
      r_fire_f = rvalid && rready;
      if (awvalid) begin
         if (aw_held && awaddr !== aw_hold) stab_bad++;
         if (awready) begin
            aw_log.push_back(awaddr);
            aw_wait = 0;
            aw_held = 1'b0;
         end else begin
            aw_wait++;
            aw_held = 1'b1;
            aw_hold = awaddr;
         end
      end
      if (wvalid) begin
         if (w_held && wdata !== w_hold) stab_bad++;
         if (wready) begin
            w_log.push_back(wdata);
            w_wait = 0;
            w_held = 1'b0;
         end else begin
            w_wait++;
            w_held = 1'b1;
            w_hold = wdata;
         end
      end
      if (done) done_cnt++;
   end

   initial begin
      clear_model();
      // reset state
      repeat (3) tick();
      check("rst_outputs_zero", 32'(any_out()), 32'd0);
      axis_rst_n = 1'b1;
      tick();

      // full job: 11 taps, len 8, stalls everywhere, awready 3 cycles after wready
      stall_en = 1'b1; aw_dly = 3; w_dly = 0; poll_need = 3;
      start_job(32'd8, 4'd11, 7);
      check("a_busy_after_start", 32'(busy), 32'd1);
      wait_done("a", 600);
      check("a_nwrites_aw", 32'(aw_log.size()), 32'd13);
      check("a_nwrites_w", 32'(w_log.size()), 32'd13);
      if (aw_log.size() == 13 && w_log.size() == 13) begin
         for (int i = 0; i < 11; i++) begin
            check($sformatf("a_tap%0d_addr", i), 32'(aw_log[i]), 32'h40 + 32'(4 * i));
            check($sformatf("a_tap%0d_data", i), w_log[i], 32'hC0DE_0000 + 32'(i));
         end
         check("a_len_addr", 32'(aw_log[11]), 32'h10);
         check("a_len_data", w_log[11], 32'd8);
         check("a_ctrl_addr", 32'(aw_log[12]), 32'h0);
         check("a_ctrl_data", w_log[12], 32'd1);
      end
      check("a_stable", 32'(stab_bad), 32'd0);
      check("a_ss_beats", 32'(ss_beats), 32'd8);
      check("a_tlast_count", 32'(ss_last_cnt), 32'd1);
      check("a_tlast_pos", 32'(ss_last_pos), 32'd7);
      check("a_ss_passthru", 32'(pass_bad), 32'd0);
      check("a_dst_count", 32'(dst_log.size()), 32'd8);
      if (dst_log.size() == 8) begin
         check("a_dst0", dst_log[0], 32'h1100);
         check("a_dst7", dst_log[7], 32'h1107);
      end
      check("a_reads", 32'(n_ar), 32'd3);
      check("a_read_addr", 32'(ar_bad), 32'd0);
      check("a_one_done", 32'(done_cnt), 32'd1);
      check("a_err", 32'(err), 32'd0);
      check("a_idle_outputs", 32'(any_out()), 32'd0);

      // ntap=0 clamps to 11; wready 3 cycles after awready
      stall_en = 1'b0; aw_dly = 0; w_dly = 3; poll_need = 1;
      start_job(32'd4, 4'd0, 3);
      wait_done("b", 400);
      check("b_nwrites", 32'(aw_log.size()), 32'd13);
      if (aw_log.size() == 13 && w_log.size() == 13) begin
         check("b_last_tap_addr", 32'(aw_log[10]), 32'h68);
         check("b_len_addr", 32'(aw_log[11]), 32'h10);
         check("b_len_data", w_log[11], 32'd4);
      end
      check("b_stable", 32'(stab_bad), 32'd0);
      check("b_dst_count", 32'(dst_log.size()), 32'd4);

      // ntap=15 clamps to 11
      aw_dly = 1; w_dly = 1;
      start_job(32'd2, 4'd15, 1);
      wait_done("c", 400);
      check("c_nwrites", 32'(w_log.size()), 32'd13);
      if (w_log.size() == 13) check("c_last_tap_data", w_log[10], 32'hC0DE_000A);

      // len=0: straight to FIN, done one cycle later, no bus traffic
      start_job(32'd0, 4'd5, 0);
      check("z_busy", 32'(busy), 32'd1);
      check("z_no_done_yet", 32'(done), 32'd0);
      tick();
      check("z_done", 32'(done), 32'd1);
      check("z_busy_drop", 32'(busy), 32'd0);
      tick();
      check("z_done_clear", 32'(done), 32'd0);
      check("z_no_writes", 32'(aw_log.size() + w_log.size()), 32'd0);
      check("z_no_reads", 32'(n_ar), 32'd0);

      // early sm_tlast on beat 5 sets err; the next start clears it
      aw_dly = 0; w_dly = 0;
      start_job(32'd8, 4'd3, 4);
      wait_done("e", 400);
      check("e_nwrites", 32'(aw_log.size()), 32'd5);
      check("e_err_set", 32'(err), 32'd1);
      start_job(32'd3, 4'd2, 2);
      check("e_err_cleared", 32'(err), 32'd0);
      wait_done("e2", 400);
      check("e2_err", 32'(err), 32'd0);
      check("e2_dst_count", 32'(dst_log.size()), 32'd3);

      // reset in the middle of STREAM
      start_job(32'd8, 4'd2, 7);
      for (int i = 0; i < 300 && ss_beats < 3; i++) tick();
      check("r_reached_stream", 32'(ss_beats >= 3), 32'd1);
      axis_rst_n = 1'b0;
      #1;
      check("r_outputs_zero", 32'(any_out()), 32'd0);
      clear_model();
      repeat (4) tick();
      axis_rst_n = 1'b1;
      repeat (6) tick();
      check("r_no_done", 32'(done_cnt), 32'd0);
      start_job(32'd3, 4'd2, 2);
      wait_done("r2", 400);
      check("r2_nwrites", 32'(aw_log.size()), 32'd4);
      check("r2_dst_count", 32'(dst_log.size()), 32'd3);
      if (dst_log.size() == 3) check("r2_dst2", dst_log[2], 32'h1102);

      // start while busy is ignored
      start_job(32'd4, 4'd2, 3);
      repeat (3) tick();
      start = 1'b1; cfg_len = 32'd0; cfg_ntap = 4'd1;
      tick();
      start = 1'b0;
      wait_done("s", 400);
      repeat (10) tick();
      check("s_one_done", 32'(done_cnt), 32'd1);
      check("s_nwrites", 32'(aw_log.size()), 32'd4);
      check("s_dst_count", 32'(dst_log.size()), 32'd4);
      check("s_len_kept", (w_log.size() == 4) ? w_log[2] : 32'hFFFF_FFFF, 32'd4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
